// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-period computation and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned BAUD_CNT_W = 16;

  // Clocks per bit period from a clock in MHz and a bit rate in bit/s.
  function automatic int unsigned calc_cycle(input int unsigned clk_fre_mhz,
                                             input int unsigned baud_rate);
    return (clk_fre_mhz * 32'd1000000) / baud_rate;
  endfunction

  // Parity over the low `width` bits; odd=1 makes the total ones count (incl. parity) odd.
  function automatic logic parity_calc(input logic [8:0]     data,
                                       input int unsigned    width,
                                       input logic           odd);
    logic p;
    p = odd;
    for (int unsigned i = 0; i < 9; i++) begin
      if (i < width) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CYCLE-1 while enabled, wraps, and flags the last clock of a period.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CYCLE = 5208
) (
  input  logic                  i_clk_sys,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_clr,
  output logic [BAUD_CNT_W-1:0] o_cnt,
  output logic                  o_bit_end
);

  localparam logic [BAUD_CNT_W-1:0] LAST_CNT = BAUD_CNT_W'(CYCLE - 1);

  logic [BAUD_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise advance and wrap at the end of each bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_cnt     = cnt_q;
  assign o_bit_end = i_en && (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word in, one start/data/parity/stop frame out on a registered line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE     = 50,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PARITY_ON   = 0,
  parameter int unsigned PARITY_TYPE = 0,
  parameter int unsigned BAUD_RATE   = 9600
) (
  input  logic                  i_clk_sys,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  output logic                  o_tx_ready,
  output logic                  o_uart_tx,
  output logic                  o_tx_done
);

  localparam int unsigned           CYCLE    = calc_cycle(CLK_FRE, BAUD_RATE);
  localparam logic [BAUD_CNT_W-1:0] LAST_CNT = BAUD_CNT_W'(CYCLE - 1);
  localparam logic [3:0]            LAST_BIT = 4'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic                  tx_q, tx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  parity_q, parity_d;

  logic                  accept;
  logic                  bit_end;
  logic [BAUD_CNT_W-1:0] baud_cnt;

  assign accept = i_data_valid && (state_q == S_IDLE);

  // The timer runs in every framed state and restarts from zero on each accepted word.
  uart_baud_cnt #(
    .CYCLE (CYCLE)
  ) u_baud_cnt (
    .i_clk_sys (i_clk_sys),
    .i_rst_n   (i_rst_n),
    .i_en      (state_q != S_IDLE),
    .i_clr     (accept),
    .o_cnt     (baud_cnt),
    .o_bit_end (bit_end)
  );

  // Frame sequencing; tx_d is the line level for the period that starts at the next edge.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d   = S_START;
          tx_d      = 1'b0;
          shift_d   = i_data;
          parity_d  = parity_calc(9'(i_data), DATA_WIDTH, PARITY_TYPE != 0);
          bit_cnt_d = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY_ON != 0) begin
              state_d = S_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        tx_d      = 1'b1;
        bit_cnt_d = '0;
      end
    endcase
  end

  // FSM and datapath registers; reset aborts any frame and parks the line high.
  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
    end
  end

  assign o_uart_tx  = tx_q;
  assign o_tx_ready = (state_q == S_IDLE);
  assign o_tx_done  = (state_q == S_STOP) && (baud_cnt == LAST_CNT);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three instances (no parity, even, odd) at 8 clocks per bit.
module tb_uart_tx;

  localparam int CYC = 8;   // 1 MHz / 125000 bit/s

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic [10:0] frame;     // bit i = i-th level on the line (start first)
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] valid;
  logic [7:0] din [3];
  logic [2:0] ready, tx, done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int frames [3];
  int aborts [3];
  int start_cyc [3];
  int prev_start [3];
  bit mon_busy [3];

  logic [10:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.CLK_FRE(1), .DATA_WIDTH(8), .PARITY_ON(0), .PARITY_TYPE(0), .BAUD_RATE(125000)) u_dut0 (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_data(din[0]), .i_data_valid(valid[0]),
    .o_tx_ready(ready[0]), .o_uart_tx(tx[0]), .o_tx_done(done[0]));
  uart_tx #(.CLK_FRE(1), .DATA_WIDTH(8), .PARITY_ON(1), .PARITY_TYPE(0), .BAUD_RATE(125000)) u_dut1 (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_data(din[1]), .i_data_valid(valid[1]),
    .o_tx_ready(ready[1]), .o_uart_tx(tx[1]), .o_tx_done(done[1]));
  uart_tx #(.CLK_FRE(1), .DATA_WIDTH(8), .PARITY_ON(1), .PARITY_TYPE(1), .BAUD_RATE(125000)) u_dut2 (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_data(din[2]), .i_data_valid(valid[2]),
    .o_tx_ready(ready[2]), .o_uart_tx(tx[2]), .o_tx_done(done[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity (1 even, 2 odd), stop 1.
  function automatic logic [10:0] frame_model(input int k, input logic [7:0] d);
    logic [10:0] f;
    f      = '0;
    f[8:1] = d;
    if (k == 0) begin
      f[9] = 1'b1;
    end else begin
      f[9]  = (k == 1) ? (^d) : ~(^d);
      f[10] = 1'b1;
    end
    return f;
  endfunction

  task automatic push(input int k, input logic [10:0] f);
    case (k)
      0:       q0.push_back(f);
      1:       q1.push_back(f);
      default: q2.push_back(f);
    endcase
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pop(input int k, output logic [10:0] f, output bit ok);
    ok = (qsize(k) != 0);
    f  = '0;
    if (ok) begin
      case (k)
        0:       f = q0.pop_front();
        1:       f = q1.pop_front();
        default: f = q2.pop_front();
      endcase
    end
  endtask

  // Watches one line: aligns on the start bit, checks every clock of the frame against the expected bit.
  task automatic monitor(input int k);
    int nb, f, errs, derr, rerr;
    logic [10:0] exp, got;
    bit ok, ab, rdy_ok;
    nb = (k == 0) ? 10 : 11;
    f  = nb * CYC;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx[k] === 1'b0) begin
        mon_busy[k]   = 1'b1;
        prev_start[k] = start_cyc[k];
        start_cyc[k]  = cyc;
        pop(k, exp, ok);
        check($sformatf("u%0d_frame_expected", k), 32'(ok), 32'd1);
        got = '0; errs = 0; derr = 0; rerr = 0; ab = 1'b0; rdy_ok = 1'b0;
        for (int c = 1; c <= f + 1; c++) begin
          if (c > 1) @(negedge clk);
          if (rst_n !== 1'b1) begin
            ab = 1'b1;
            break;
          end
          if (c <= f) begin
            if (tx[k] !== exp[(c-1)/CYC]) errs++;
            if ((c-1) % CYC == CYC/2) got[(c-1)/CYC] = tx[k];
            if (done[k] !== (c == f)) derr++;
            if (ready[k] !== 1'b0) rerr++;
          end else begin
            rdy_ok = (ready[k] === 1'b1) && (tx[k] === 1'b1) && (done[k] === 1'b0);
          end
        end
        if (ab) begin
          aborts[k]++;
        end else begin
          check($sformatf("u%0d_frame_bits", k), 32'(got), 32'(exp));
          check($sformatf("u%0d_line_timing_errs", k), 32'(errs), 32'd0);
          check($sformatf("u%0d_done_pulse_errs", k), 32'(derr), 32'd0);
          check($sformatf("u%0d_ready_busy_errs", k), 32'(rerr), 32'd0);
          check($sformatf("u%0d_ready_after_done", k), 32'(rdy_ok), 32'd1);
          frames[k]++;
        end
        mon_busy[k] = 1'b0;
      end
    end
  endtask

  // Waits for ready, presents one word and pushes its expected frame; hold leaves valid asserted.
  task automatic send(input int k, input logic [7:0] d, input logic [10:0] f, input bit hold);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ready[k] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("u%0d_send_ready_wait", k), 32'(ok), 32'd1);
    din[k]   = d;
    valid[k] = 1'b1;
    push(k, f);
    @(posedge clk);
    #1;
    if (!hold) valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (qsize(k) == 0 && !mon_busy[k] && ready[k] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("u%0d_idle_wait", k), 32'(ok), 32'd1);
  endtask

  task automatic rand_run(input int k, input int n);
    logic [7:0] d;
    for (int j = 0; j < n; j++) begin
      d = 8'($urandom);
      send(k, d, frame_model(k, d), 1'b0);
    end
    wait_idle(k);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [10];
    int   f0, dn, bad;

    tbl[0] = '{0, 8'hA5, 11'b01101001010};
    tbl[1] = '{1, 8'h07, 11'b11000001110};
    tbl[2] = '{2, 8'h07, 11'b10000001110};
    tbl[3] = '{0, 8'h00, 11'b01000000000};
    tbl[4] = '{0, 8'hFF, 11'b01111111110};
    tbl[5] = '{1, 8'h00, 11'b10000000000};
    tbl[6] = '{2, 8'h00, 11'b11000000000};
    tbl[7] = '{1, 8'hFF, 11'b10111111110};
    tbl[8] = '{2, 8'h80, 11'b10100000000};
    tbl[9] = '{1, 8'h80, 11'b11100000000};

    for (int k = 0; k < 3; k++) begin
      frames[k] = 0; aborts[k] = 0; start_cyc[k] = 0; prev_start[k] = 0; mon_busy[k] = 1'b0;
      din[k] = '0;
    end
    valid = '0;
    rst_n = 1'b0;

    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none

    // Reset held for 5 clocks: line high, ready high, no done on every instance.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        check($sformatf("u%0d_rst_tx", k), 32'(tx[k]), 32'd1);
        check($sformatf("u%0d_rst_ready", k), 32'(ready[k]), 32'd1);
        check($sformatf("u%0d_rst_done", k), 32'(done[k]), 32'd0);
      end
    end
    rst_n = 1'b1;

    // Directed frames, one at a time.
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].inst, tbl[i].data, tbl[i].frame, 1'b0);
      wait_idle(tbl[i].inst);
    end

    // Back-to-back with valid held: second word accepted in the first ready cycle after done.
    send(0, 8'h00, 11'b01000000000, 1'b1);
    din[0] = 8'hFF;
    push(0, 11'b01111111110);
    bad = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ready[0] === 1'b1) begin
        bad = 0;
        break;
      end
    end
    check("u0_b2b_ready_wait", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    wait_idle(0);
    check("u0_b2b_start_gap", 32'(start_cyc[0] - prev_start[0]), 32'(10 * CYC + 1));

    // Valid pulses while busy must not start another frame.
    f0 = frames[1];
    send(1, 8'h3C, frame_model(1, 8'h3C), 1'b0);
    repeat (20) @(negedge clk);
    din[1]   = 8'h99;
    valid[1] = 1'b1;
    repeat (3) @(negedge clk);
    valid[1] = 1'b0;
    wait_idle(1);
    repeat (2 * CYC) @(negedge clk);
    check("u1_busy_pulse_frames", 32'(frames[1] - f0), 32'd1);

    // Reset during data bit 3 aborts the frame: line high next clock, no done pulse.
    send(0, 8'h5A, frame_model(0, 8'h5A), 1'b0);
    repeat (34) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("u0_midrst_tx", 32'(tx[0]), 32'd1);
    check("u0_midrst_ready", 32'(ready[0]), 32'd1);
    check("u0_midrst_done", 32'(done[0]), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dn = 0; bad = 0;
    for (int i = 0; i < 12 * CYC; i++) begin
      @(negedge clk);
      if (done[0] !== 1'b0) dn++;
      if (tx[0] !== 1'b1) bad++;
    end
    check("u0_midrst_no_done", 32'(dn), 32'd0);
    check("u0_midrst_line_high", 32'(bad), 32'd0);
    check("u0_midrst_aborts", 32'(aborts[0]), 32'd1);
    check("u0_midrst_queue", 32'(qsize(0)), 32'd0);

    // Random words on all three instances in parallel (258 total).
    fork
      rand_run(0, 86);
      rand_run(1, 86);
      rand_run(2, 86);
    join

    for (int k = 0; k < 3; k++) check($sformatf("u%0d_final_queue", k), 32'(qsize(k)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
